dqn_action_select: RTL and testbench

Parametrised Q-value arg-max / epsilon-greedy action selector for the DQN datapath. It sits between the output layer of forward propagation and the backward pass. It consumes the N_ACT output-layer Q-values of one state as a serial stream and returns the selected action index and the maximum Q-value. It generalises the fixed 4-action, 16-bit action determiner with these additions:
- arbitrary action count and data width;
- a valid/ready input handshake;
- a built-in LFSR for exploration;
- a target mode that computes max-Q only, for the next-state (maxQt1) pass.

---
 rtl/dqn_action_select.sv | 124 ++++++++++++
 tb/tb_dqn_action_select.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dqn_action_select.sv
// Serial Q-value arg-max / epsilon-greedy action selector.
// Optional feature macro: EPS_GREEDY_EN (LFSR-driven exploration in act mode).
module dqn_action_select #(
    parameter int W     = 16,
    parameter int N_ACT = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             q_valid,
    input  logic [W-1:0]     q_data,
    output logic             q_ready,
    input  logic [15:0]      eps,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] action,
    output logic [W-1:0]     max_q,
    output logic             explored
);

    typedef enum logic [1:0] {IDLE, SCAN, RESOLVE, DONE} state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] cnt;
    logic [W-1:0]     best_q;
    logic [IDX_W-1:0] best_idx;
    logic             mode_q;
    logic             hs;
    logic             last;
    logic             explore;
    logic [IDX_W-1:0] rand_idx;

    // A sample is consumed only on q_valid && q_ready; q_ready is high only in SCAN.
    assign hs   = q_valid && q_ready;
    assign last = (cnt == IDX_W'(N_ACT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        q_ready  = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = SCAN;
            end
            SCAN: begin
                q_ready = 1'b1;
                if (hs && last) state_nx = RESOLVE;
            end
            RESOLVE: state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // done is registered from DONE so the strobe lands in the first IDLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            best_q   <= '0;
            best_idx <= '0;
            mode_q   <= 1'b0;
            done     <= 1'b0;
            action   <= '0;
            max_q    <= '0;
            explored <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        mode_q <= mode;
                    end
                end
                SCAN: begin
                    if (hs) begin
                        if (cnt == '0 || $signed(q_data) > $signed(best_q)) begin
                            best_q   <= q_data;
                            best_idx <= cnt;
                        end
                        if (!last) cnt <= cnt + 1'b1;
                    end
                end
                RESOLVE: begin
                    max_q    <= best_q;
                    action   <= explore ? rand_idx : best_idx;
                    explored <= explore;
                end
                default: ;
            endcase
        end
    end

`ifdef EPS_GREEDY_EN
    logic [15:0]    lfsr;
    logic [IDX_W:0] r_ext;

    // Galois LFSR, x^16+x^14+x^13+x^11+1; free-running, never reaches zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign r_ext    = {1'b0, lfsr[IDX_W-1:0]};
    assign rand_idx = (r_ext >= (IDX_W+1)'(N_ACT)) ? IDX_W'(r_ext - (IDX_W+1)'(N_ACT))
                                                   : lfsr[IDX_W-1:0];
    assign explore  = !mode_q && (lfsr <= eps);
`else
    logic unused_cfg;

    assign explore    = 1'b0;
    assign rand_idx   = '0;
    assign unused_cfg = ^{eps, mode_q};
`endif

endmodule

// File: tb/tb_dqn_action_select.sv
// Bench for dqn_action_select: directed and randomized ops on a 4-action and a 9-action instance.
module tb_dqn_action_select;

    logic clk = 1'b0;
    logic rst;

    logic        start, mode, q_valid, q_ready, busy, done, explored;
    logic [15:0] q_data, eps, max_q;
    logic [1:0]  action;

    logic        b_start, b_mode, b_q_valid, b_q_ready, b_busy, b_done, b_explored;
    logic [15:0] b_q_data, b_eps, b_max_q;
    logic [3:0]  b_action;

    logic [15:0] m_lfsr;
    logic [15:0] qs[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    dqn_action_select #(.W(16), .N_ACT(4), .IDX_W(2)) u_a (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .q_valid(q_valid),
        .q_data(q_data), .q_ready(q_ready), .eps(eps), .busy(busy), .done(done),
        .action(action), .max_q(max_q), .explored(explored)
    );

    dqn_action_select #(.W(16), .N_ACT(9), .IDX_W(4)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .q_valid(b_q_valid),
        .q_data(b_q_data), .q_ready(b_q_ready), .eps(b_eps), .busy(b_busy), .done(b_done),
        .action(b_action), .max_q(b_max_q), .explored(b_explored)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Reference pseudo-random sequence: one step per clock edge out of reset.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= lfsr_next(m_lfsr);
    end

    function automatic int argmax(input logic [15:0] v[$]);
        int bi = 0;
        for (int i = 1; i < v.size(); i++)
            if ($signed(v[i]) > $signed(v[bi])) bi = i;
        return bi;
    endfunction

    function automatic int pick(input int n, input int iw, input logic m, input logic [15:0] lf,
                                input logic [15:0] e, input int bi, output logic ex);
`ifdef EPS_GREEDY_EN
        ex = !m && (lf <= e);
`else
        ex = 1'b0;
`endif
        return ex ? (int'(lf) % (1 << iw)) % n : bi;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One op on the 4-action instance using qs; gap_len idle cycles inserted before sample gap_at.
    task automatic run_op(input string tag, input logic m, input logic [15:0] e,
                          input int gap_at, input int gap_len, input bit poke);
        logic [15:0] lf;
        logic        ex;
        int          bi, ea;
        start = 1'b1; mode = m; eps = e;
        tick();
        start = 1'b0; mode = ~m;
        check({tag, ".busy_scan"}, 16'(busy), 16'd1);
        check({tag, ".rdy_scan"}, 16'(q_ready), 16'd1);
        for (int k = 0; k < 4; k++) begin
            if (k == gap_at) begin
                repeat (gap_len) begin
                    q_valid = 1'b0; q_data = 16'($urandom);
                    tick();
                    check({tag, ".rdy_gap"}, 16'(q_ready), 16'd1);
                end
            end
            q_valid = 1'b1; q_data = qs[k];
            start = poke && (k == 1);
            tick();
            start = 1'b0;
        end
        q_valid = 1'b0; q_data = 16'($urandom);
        lf = m_lfsr;
        check({tag, ".rdy_resolve"}, 16'(q_ready), 16'd0);
        check({tag, ".busy_resolve"}, 16'(busy), 16'd1);
        check({tag, ".done_early"}, 16'(done), 16'd0);
        tick();
        bi = argmax(qs);
        ea = pick(4, 2, m, lf, e, bi, ex);
        check({tag, ".done_k1"}, 16'(done), 16'd0);
        check({tag, ".action"}, 16'(action), 16'(ea));
        check({tag, ".max_q"}, max_q, qs[bi]);
        check({tag, ".explored"}, 16'(explored), 16'(ex));
        start = poke;
        tick();
        start = 1'b0;
        check({tag, ".done"}, 16'(done), 16'd1);
        check({tag, ".busy_done"}, 16'(busy), 16'd0);
        tick();
        check({tag, ".done_width"}, 16'(done), 16'd0);
        check({tag, ".no_restart"}, 16'(busy), 16'd0);
    endtask

    task automatic run_b(input logic m);
        logic [15:0] bq[$];
        logic [15:0] lf;
        logic        ex;
        int          bi, ea;
        b_start = 1'b1; b_mode = m; b_eps = 16'hFFFF;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            b_q_valid = 1'b1;
            b_q_data  = (k % 3 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            bq.push_back(b_q_data);
            tick();
        end
        b_q_valid = 1'b0;
        lf = m_lfsr;
        tick();
        bi = argmax(bq);
        ea = pick(9, 4, m, lf, 16'hFFFF, bi, ex);
        check("b.action_range", 16'(b_action < 4'd9), 16'd1);
        check("b.action", 16'(b_action), 16'(ea));
        check("b.max_q", b_max_q, bq[bi]);
        check("b.explored", 16'(b_explored), 16'(ex));
        tick();
        check("b.done", 16'(b_done), 16'd1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; mode = 1'b0; q_valid = 1'b0; q_data = '0; eps = '0;
        b_start = 1'b0; b_mode = 1'b0; b_q_valid = 1'b0; b_q_data = '0; b_eps = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.q_ready", 16'(q_ready), 16'd0);
        check("rst.busy", 16'(busy), 16'd0);
        check("rst.done", 16'(done), 16'd0);
        check("rst.action", 16'(action), 16'd0);
        check("rst.max_q", max_q, 16'd0);
        check("rst.explored", 16'(explored), 16'd0);
        check("rst.b_busy", 16'(b_busy), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        qs = '{16'd5, -16'd3, 16'd12, 16'd12};
        run_op("t1", 1'b0, 16'h0000, 9, 0, 1'b0);
        qs = '{-16'd100, -16'd7, -16'd7, -16'd50};
        run_op("t2", 1'b1, 16'h1234, 2, 3, 1'b0);
        qs = '{16'd1, 16'd2, 16'd3, 16'd4};
        run_op("t3", 1'b0, 16'hFFFF, 9, 0, 1'b0);
        run_op("t3m1", 1'b1, 16'hFFFF, 9, 0, 1'b0);

        // Abort mid-operation with an asynchronous reset.
        start = 1'b1; mode = 1'b0; eps = 16'hFFFF;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            q_valid = 1'b1; q_data = 16'd77;
            tick();
        end
        q_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("abort.q_ready", 16'(q_ready), 16'd0);
        check("abort.busy", 16'(busy), 16'd0);
        check("abort.done", 16'(done), 16'd0);
        check("abort.action", 16'(action), 16'd0);
        check("abort.max_q", max_q, 16'd0);
        check("abort.explored", 16'(explored), 16'd0);
        #1 rst = 1'b0;
        tick();
        qs = '{16'd0, 16'd9, 16'd0, 16'd0};
        run_op("t4", 1'b1, 16'h0000, 9, 0, 1'b0);

        qs = '{16'd3, 16'd40, -16'd2, 16'd40};
        run_op("t5poke", 1'b0, 16'h0000, 9, 0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            qs = {};
            for (int k = 0; k < 4; k++)
                qs.push_back((i % 2) ? 16'($urandom_range(0, 2)) : 16'($urandom));
            run_op("rnd", 1'($urandom_range(0, 1)), 16'($urandom),
                   $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 200; i++)
            run_b(1'($urandom_range(0, 3) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
